// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter scheduler: state encoding,
// round-robin pick and run-length clamp.
package counter_sched_pkg;

    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} sched_state_e;

    // One-hot grant of the first set bit at or after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (g == '0 && req[idx]) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_W-1:0] i;
        i = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) i = PTR_W'(k);
        end
        return i;
    endfunction

    // A zero field means "full run"; anything above max is clamped.
    function automatic logic [31:0] clamp_limit(input logic [31:0] field,
                                                input logic [31:0] max);
        return (field == 32'd0 || field > max) ? max : field;
    endfunction

endpackage

// File: rtl/counter_sched_rr_arb.sv
// Round-robin picker with its pointer register; the pointer moves to one
// past the owner recorded at grant time whenever a run ends.
module counter_sched_rr_arb
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             take,
    input  logic             advance,
    output logic [N_REQ-1:0] pick
);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [MAX_REQ-1:0] pick_full;

    assign pick_full = rr_pick(MAX_REQ'(req), ptr_q, N_REQ);
    assign pick      = pick_full[N_REQ-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            if (take) owner_q <= onehot_idx(pick_full);
            if (advance) ptr_q <= (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + PTR_W'(1);
        end
    end

endmodule

// File: rtl/counter_sched_ctrl.sv
// Time-shares one external up-counter among N_REQ requesters (clear, enable,
// observe). Optional stall watchdog built when COUNTER_SCHED_TIMEOUT_EN is defined.
module counter_sched_ctrl
    import counter_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int CNT_W     = 4,
`ifdef COUNTER_SCHED_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 16,
`endif
    parameter int MAX_VALUE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*CNT_W-1:0] req_limit,
    input  logic               abort,
    input  logic [CNT_W-1:0]   cnt_count,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic               err,
    output sched_state_e       dbg_state
);

    // Handshake: req[i] is a level held until done[i] pulses; dropping it
    // while owning the counter (CLEAR/RUN) cancels the run like abort.
    sched_state_e     state;
    logic [N_REQ-1:0] gnt_q, done_q, pick;
    logic             clr_q, err_q;
    logic [CNT_W-1:0] limit_q, sel_field, limit_next;
    logic             grant, kill, terminal, owner_req, wd_fire;

    always_comb begin
        sel_field = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) sel_field = req_limit[i*CNT_W +: CNT_W];
        end
    end

    assign limit_next = CNT_W'(clamp_limit(32'(sel_field), 32'(MAX_VALUE)));
    assign terminal   = (cnt_count == limit_q);
    assign owner_req  = |(req & gnt_q);
    assign grant      = (state == IDLE) && (|req);
    assign kill       = ((state != IDLE) && abort)
                      || (((state == CLEAR) || (state == RUN)) && !owner_req)
                      || wd_fire;

    counter_sched_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .take    (grant),
        .advance (kill || (state == DONE)),
        .pick    (pick)
    );

`ifdef COUNTER_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]  wd_q;
    logic [CNT_W-1:0] prev_q;

    // wd_q counts RUN cycles spent at the current count value, change cycle included.
    assign wd_fire = (state == RUN) && !terminal && (cnt_count == prev_q)
                   && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q   <= '0;
            prev_q <= '0;
        end else begin
            prev_q <= cnt_count;
            if (state != RUN)               wd_q <= '0;
            else if (cnt_count != prev_q)   wd_q <= WD_W'(1);
            else if (!wd_fire)              wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
            limit_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            clr_q  <= 1'b0;
            if (kill) begin
                state <= IDLE;
                gnt_q <= '0;
                err_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (grant) begin
                        state   <= CLEAR;
                        gnt_q   <= pick;
                        limit_q <= limit_next;
                        clr_q   <= 1'b1;
                    end
                    CLEAR: state <= RUN;
                    RUN: if (terminal) begin
                        state  <= DONE;
                        done_q <= gnt_q;
                    end
                    DONE: begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Enable drops in the same cycle the count reaches the limit.
    assign cnt_en    = (state == RUN) && !terminal;
    assign cnt_clr   = clr_q;
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// Directed bench for counter_sched_ctrl with a behavioural shared counter
// and an expected grant-order queue.
module tb_counter_sched_ctrl;
    import counter_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_limit;
    logic           abort;
    logic [W-1:0]   cnt_count = '0;
    logic           cnt_clr, cnt_en, busy, err;
    logic [N-1:0]   gnt, done;
    sched_state_e   dbg_state;
    logic           hold;

    int errors = 0;
    int checks = 0;
    int busy_n, en_n, clr_n, err_n, inv_n, done_cnt_v;
    int done_n[N];
    logic [N-1:0] prev_gnt = '0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];
    bit drop_on_done;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    counter_sched_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_limit (req_limit),
        .abort     (abort),
        .cnt_count (cnt_count),
        .cnt_clr   (cnt_clr),
        .cnt_en    (cnt_en),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // shared counter model; hold freezes it to emulate a stall
    always @(posedge clk) begin
        if (cnt_clr)                cnt_count <= '0;
        else if (cnt_en && !hold)   cnt_count <= cnt_count + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        busy_n = 0; en_n = 0; clr_n = 0; err_n = 0; done_cnt_v = -1;
        for (int i = 0; i < N; i++) done_n[i] = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    // driver: advance one clock, then sample and collect statistics
    task automatic step();
        @(posedge clk);
        #1;
        if (busy)    busy_n++;
        if (cnt_en)  en_n++;
        if (cnt_clr) clr_n++;
        if (err)     err_n++;
        if (!$onehot0(gnt) || ((done & ~gnt) != '0) || (cnt_clr && cnt_en)) inv_n++;
        if (gnt != '0 && prev_gnt == '0) got_q.push_back(gnt);
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                done_n[i]++;
                done_cnt_v = int'(cnt_count);
                if (drop_on_done) req[i] = 1'b0;
            end
        end
        prev_gnt = gnt;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b0; req = '0; req_limit = '0; abort = 1'b0; hold = 1'b0;
        drop_on_done = 1'b0; inv_n = 0;
        clr_stats();
        steps(2);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_clr", 32'(cnt_clr), 0);
        chk("rst_en", 32'(cnt_en), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        step();

        // single requester, limit 5
        clr_stats(); drop_on_done = 1'b1;
        req_limit = 16'h0005; req = 4'b0001;
        step();
        chk("t1_gnt_latency", 32'(gnt), 1);
        chk("t1_clr_first", 32'(cnt_clr), 1);
        steps(11);
        chk("t1_busy_cycles", busy_n, 8);
        chk("t1_en_cycles", en_n, 5);
        chk("t1_clr_cycles", clr_n, 1);
        chk("t1_done_pulses", done_n[0], 1);
        chk("t1_done_count", done_cnt_v, 5);
        chk("t1_no_err", err_n, 0);
        chk("t1_gnt_idle", 32'(gnt), 0);

        // fairness: all requesting, limit 2, held through 8 runs
        reset = 1'b0; step(); reset = 1'b1; step();
        clr_stats(); drop_on_done = 1'b0;
        req_limit = 16'h2222; req = 4'b1111;
        steps(48);
        req = '0;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
            exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        end
        chk("fair_grant_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) chk("fair_order", 32'(got_q[i]), 32'(exp_q[i]));
        end
        for (int i = 0; i < N; i++) chk("fair_done_each", done_n[i], 2);
        steps(4);

        // clamp: 15 -> 8, then 0 -> 8
        clr_stats(); drop_on_done = 1'b1;
        req_limit = 16'h000F; req = 4'b0001;
        steps(14);
        chk("clamp15_done", done_n[0], 1);
        chk("clamp15_count", done_cnt_v, 8);
        chk("clamp15_en", en_n, 8);
        chk("clamp15_busy", busy_n, 11);
        clr_stats();
        req_limit = 16'h0000; req = 4'b0010;
        steps(14);
        chk("clamp0_done", done_n[1], 1);
        chk("clamp0_count", done_cnt_v, 8);

        // abort on 3rd RUN cycle of requester 2 with requester 3 pending
        clr_stats(); drop_on_done = 1'b0;
        req_limit = 16'h2600; req = 4'b1100;
        step();
        chk("abort_gnt2", 32'(gnt), 4);
        steps(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_err", 32'(err), 1);
        chk("abort_gnt_drop", 32'(gnt), 0);
        chk("abort_no_done", done_n[2], 0);
        chk("abort_busy", 32'(busy), 0);
        step();
        chk("abort_next_owner", 32'(gnt), 8);
        chk("abort_err_pulse", 32'(err), 0);
        req = 4'b1000; drop_on_done = 1'b1;
        steps(8);
        chk("abort_next_done", done_n[3], 1);
        chk("abort_next_count", done_cnt_v, 2);
        chk("abort_err_once", err_n, 1);

        // abort while idle is ignored
        abort = 1'b1; step(); abort = 1'b0;
        chk("idle_abort_err", 32'(err), 0);
        chk("idle_abort_busy", 32'(busy), 0);

        // owner drops req during RUN
        clr_stats(); drop_on_done = 1'b0;
        req_limit = 16'h0005; req = 4'b0001;
        steps(3);
        req = '0;
        step();
        chk("drop_err", 32'(err), 1);
        chk("drop_gnt", 32'(gnt), 0);
        chk("drop_no_done", done_n[0], 0);

        // abort coincides with terminal count
        clr_stats();
        req_limit = 16'h0010; req = 4'b0010;
        steps(3);
        chk("term_en_low", 32'(cnt_en), 0);
        chk("term_count", 32'(cnt_count), 1);
        abort = 1'b1;
        step();
        abort = 1'b0; req = '0;
        chk("term_abort_err", 32'(err), 1);
        chk("term_abort_no_done", done_n[1], 0);
        step();

        // reset mid-run, then pointer restarts at 0
        clr_stats();
        req_limit = 16'h0500; req = 4'b0100;
        steps(3);
        chk("rrun_busy", 32'(busy), 1);
        reset = 1'b0;
        step();
        chk("rrun_gnt", 32'(gnt), 0);
        chk("rrun_en", 32'(cnt_en), 0);
        chk("rrun_busy_off", 32'(busy), 0);
        chk("rrun_done", 32'(done), 0);
        chk("rrun_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1; req = 4'b1010; req_limit = 16'h3333;
        step();
        chk("rrun_ptr_reset", 32'(gnt), 2);
        req = '0;
        steps(2);

        // stalled counter: no watchdog in this build, stays busy
        clr_stats();
        req_limit = 16'h0005; req = 4'b0001;
        steps(4);
        chk("stall_pre_count", 32'(cnt_count), 2);
        hold = 1'b1;
        clr_stats();
        steps(100);
        chk("stall_busy", busy_n, 100);
        chk("stall_count", 32'(cnt_count), 2);
        abort = 1'b1;
        step();
        abort = 1'b0; req = '0; hold = 1'b0;
        chk("stall_abort_err", 32'(err), 1);
        chk("stall_abort_busy", 32'(busy), 0);
        steps(2);

        chk("invariants", inv_n, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_sched_ctrl.md
Name: counter_sched_ctrl

Overview:
- Time-shares one external up-counter (count width CNT_W, terminal value MAX_VALUE) among N_REQ requesters.
- Arbitrates requests round-robin and clears the counter for the winner.
- Enables counting until the winner's requested limit is reached, then pulses that requester's done.
- Sits between client blocks and the shared counter instance. The controller never holds the count itself; it only sequences clear/enable and observes the count.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 4, width of counter value and of each limit field.
- MAX_VALUE, 8, largest legal run length; limits above it are clamped.
- TIMEOUT_CYC, 16, stall watchdog threshold in cycles (optional feature only).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  N_REQ  level request per requester; held until done.
- req_limit  in  N_REQ*CNT_W  packed run lengths, field i = bits [i*CNT_W +: CNT_W].
- abort  in  1  terminates current run immediately.
- cnt_count  in  CNT_W  current value of the shared counter.
- cnt_clr  out  1  synchronous clear to counter.
- cnt_en  out  1  count enable to counter.
- gnt  out  N_REQ  one-hot owner of the counter; zero when idle.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on abort (and on timeout when the optional feature is enabled).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, round-robin pointer=0, latched limit=0.
  - All outputs 0.
  - Reset mid-run drops gnt and cnt_en on the next edge, with no done pulse.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, wrapping modulo N_REQ.
  - On the grant, latch limit = min(req_limit field, MAX_VALUE); a field of 0 is treated as MAX_VALUE.
  - Next state is CLEAR.
  - gnt asserts in the cycle after arbitration and stays stable until leaving DONE.
- CLEAR: cnt_clr=1, cnt_en=0, lasts exactly one cycle, then RUN.
- RUN:
  - cnt_en=1.
  - When cnt_count == latched limit, deassert cnt_en in that same cycle (combinational compare), go to DONE.
  - Counter value therefore freezes at the limit.
- DONE:
  - done[owner]=1 for one cycle.
  - Pointer = owner+1 mod N_REQ.
  - gnt drops, next state IDLE.
  - Arbitration restarts no earlier than the following cycle, so there is one idle cycle between owners.
- Latency from req to first cnt_en: 3 cycles (arbitrate, CLEAR, RUN).
- Run of limit L occupies gnt for L+3 cycles.
- Owner drops req during CLEAR/RUN: treated as abort. Go to IDLE, pulse err, no done, pointer advances.
- abort in any non-IDLE state: same as above.
- abort asserted in IDLE: ignored.
- abort and terminal count in the same cycle: abort wins.
- Non-owner req changes during a run: no effect until IDLE.
- Limit field changes after grant: ignored, since the limit is latched.
- Invariants:
  - gnt is one-hot or zero.
  - cnt_clr and cnt_en are never both high.
  - done is a subset of gnt.

Optional Feature:
- Macro: COUNTER_SCHED_TIMEOUT_EN.
- When defined, a watchdog counter ($clog2(TIMEOUT_CYC+1) bits) runs in RUN:
  - It resets whenever cnt_count changes.
  - If cnt_count stays unchanged for TIMEOUT_CYC consecutive RUN cycles, pulse err and return to IDLE, with no done and pointer advanced.
- When undefined:
  - No watchdog logic is built.
  - A stalled counter keeps RUN indefinitely; only abort, req drop or reset exits.

Decomposition:
- Package counter_sched_pkg holds:
  - state enum sched_state_e {IDLE, CLEAR, RUN, DONE};
  - function rr_pick(req, ptr) returning a one-hot grant;
  - function clamp_limit(field, max).
- One natural sub-module: counter_sched_rr_arb, the combinational round-robin picker plus pointer register, instantiated once.

Test Plan:
- Single requester: req=4'b0001, limit=5 → gnt=0001 after 1 cycle, cnt_clr for 1 cycle, cnt_en 5 cycles, done[0] pulse when count==5, busy for 8 cycles.
- Fairness: req=4'b1111, all limits=2, held → grant order 0,1,2,3,0; each done pulse once per round; no starvation across 8 runs.
- Clamp: limit=15 with MAX_VALUE=8 → counter stops at 8, done pulses. Limit=0 → also runs to 8.
- Abort: abort at 3rd RUN cycle of requester 2 → err pulse, done stays 0, gnt=0 next cycle; next grant goes to requester 3 if pending.
- Reset: reset=0 during RUN → next edge all outputs 0, state IDLE. Released with req=0010 → requester 1 granted (pointer back to 0, first set bit).
- With COUNTER_SCHED_TIMEOUT_EN: cnt_count held at 2 in RUN → err exactly TIMEOUT_CYC=16 cycles after last change, return to IDLE. Without the macro, same stimulus → busy stays 1 for 100 cycles.
